bridge_driver_nleg: RTL and testbench

Parametrised gate-drive stage for N half-bridge legs, placed between the control law (hybrid/phi controller producing per-leg switch commands) and the `OUT` pins. It supersedes the fixed 4-bit dead-time block and the combinational ENABLE/ALERT gating. It adds per-leg complementary outputs with a runtime-programmable dead time, a synchronised external trip input, a latched fault and a clean shutdown on enable loss.

---
 rtl/bridge_driver_pkg.sv | 19 +
 rtl/dead_time_leg.sv | 84 ++++++++
 rtl/bridge_driver_nleg.sv | 77 +++++++
 tb/tb_bridge_driver_nleg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_driver_pkg.sv
// Shared definitions for the N-leg gate-drive stage: leg state encoding and
// the dead-time floor applied when software programs zero.
package bridge_driver_pkg;

    localparam logic [1:0] LegOff  = 2'b00;
    localparam logic [1:0] LegDead = 2'b01;
    localparam logic [1:0] LegHi   = 2'b10;
    localparam logic [1:0] LegLo   = 2'b11;

    localparam int unsigned MinDeadTime = 1;

    typedef enum logic [1:0] {
        StOff  = LegOff,
        StDead = LegDead,
        StHi   = LegHi,
        StLo   = LegLo
    } leg_state_e;

endpackage

// File: rtl/dead_time_leg.sv
// One half-bridge leg: OFF/DEAD/HI/LO state machine with a dead-time
// down-counter and registered complementary gate outputs.
module dead_time_leg
    import bridge_driver_pkg::*;
#(
    parameter int unsigned DtWidth = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               run_i,
    input  logic               cmd_i,
    input  logic [DtWidth-1:0] deadtime_i,
    output logic               gate_hi_o,
    output logic               gate_lo_o,
    output logic               active_o
);

    leg_state_e         state_q, state_d;
    logic [DtWidth-1:0] cnt_q, cnt_d;
    logic               gate_hi_q, gate_hi_d;
    logic               gate_lo_q, gate_lo_d;
    logic [DtWidth-1:0] dt_eff;

    assign dt_eff = (deadtime_i < DtWidth'(MinDeadTime)) ? DtWidth'(MinDeadTime) : deadtime_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run_i) begin
            state_d = StOff;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StDead;
                    cnt_d   = dt_eff;
                end
                StDead: begin
                    // Target side is chosen only at expiry, so reversals never shorten the gap.
                    if (cnt_q <= DtWidth'(MinDeadTime)) begin
                        state_d = cmd_i ? StHi : StLo;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DtWidth'(1);
                    end
                end
                StHi: begin
                    if (!cmd_i) begin
                        state_d = StDead;
                        cnt_d   = dt_eff;
                    end
                end
                StLo: begin
                    if (cmd_i) begin
                        state_d = StDead;
                        cnt_d   = dt_eff;
                    end
                end
            endcase
        end
    end

    assign gate_hi_d = (state_d == StHi);
    assign gate_lo_d = (state_d == StLo);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi_o = gate_hi_q;
    assign gate_lo_o = gate_lo_q;
    assign active_o  = (state_q == StHi) || (state_q == StLo);

endmodule

// File: rtl/bridge_driver_nleg.sv
// N-leg gate-drive stage: trip synchroniser, latched fault, shoot-through
// check and the per-leg dead-time state machines.
module bridge_driver_nleg
    import bridge_driver_pkg::*;
#(
    parameter int unsigned N_LEGS   = 2,
    parameter int unsigned DT_WIDTH = 10
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [N_LEGS-1:0]   i_cmd,
    input  logic [DT_WIDTH-1:0] i_deadtime,
    input  logic                i_trip_n,
    input  logic                i_fault_clear,
    output logic [N_LEGS-1:0]   o_gate_hi,
    output logic [N_LEGS-1:0]   o_gate_lo,
    output logic                o_fault,
    output logic                o_active
);

    logic [1:0]        trip_sync_q, trip_sync_d;
    logic              trip_ok;
    logic              fault_q, fault_d;
    logic              fault_set, fault_clr;
    logic              shoot_through;
    logic              run;
    logic [N_LEGS-1:0] leg_active;

    assign trip_sync_d   = {trip_sync_q[0], i_trip_n};
    assign trip_ok       = trip_sync_q[1];
    assign shoot_through = |(o_gate_hi & o_gate_lo);

    assign fault_set = ~trip_ok | shoot_through;
    assign fault_clr = i_fault_clear & trip_ok & ~i_enable;

    always_comb begin
        fault_d = fault_q;
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    // Gating on the next fault value drops the gates on the same edge the fault latches.
    assign run = i_enable & ~fault_d;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            trip_sync_q <= 2'b11;
            fault_q     <= 1'b0;
        end else begin
            trip_sync_q <= trip_sync_d;
            fault_q     <= fault_d;
        end
    end

    for (genvar j = 0; j < N_LEGS; j++) begin : g_leg
        dead_time_leg #(
            .DtWidth(DT_WIDTH)
        ) u_leg (
            .clk_i     (i_clock),
            .rst_ni    (i_reset),
            .run_i     (run),
            .cmd_i     (i_cmd[j]),
            .deadtime_i(i_deadtime),
            .gate_hi_o (o_gate_hi[j]),
            .gate_lo_o (o_gate_lo[j]),
            .active_o  (leg_active[j])
        );
    end

    assign o_fault  = fault_q;
    assign o_active = |leg_active;

endmodule

// File: tb/tb_bridge_driver_nleg.sv
// Scoreboard bench: stimulus pushes cycle-stamped expectations, a negedge
// monitor pops and compares; a second 4-leg instance measures dead gaps.
module tb_bridge_driver_nleg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 2-leg instance, directed checks
    logic       i_reset = 1'b0;
    logic       i_enable = 1'b0;
    logic [1:0] i_cmd = 2'b01;
    logic [9:0] i_deadtime = 10'd5;
    logic       i_trip_n = 1'b1;
    logic       i_fault_clear = 1'b0;
    logic [1:0] o_gate_hi, o_gate_lo;
    logic       o_fault, o_active;

    bridge_driver_nleg #(.N_LEGS(2), .DT_WIDTH(10)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_cmd(i_cmd),
        .i_deadtime(i_deadtime), .i_trip_n(i_trip_n), .i_fault_clear(i_fault_clear),
        .o_gate_hi(o_gate_hi), .o_gate_lo(o_gate_lo), .o_fault(o_fault), .o_active(o_active)
    );

    // 4-leg instance, scaling
    logic        rst2_n = 1'b0;
    logic        en2 = 1'b0;
    logic [3:0]  cmd2 = 4'b0101;
    logic [11:0] dt2 = 12'd4095;
    logic        trip2_n = 1'b1;
    logic        clr2 = 1'b0;
    logic [3:0]  g2_hi, g2_lo;
    logic        fault2, active2;

    bridge_driver_nleg #(.N_LEGS(4), .DT_WIDTH(12)) dut4 (
        .i_clock(clk), .i_reset(rst2_n), .i_enable(en2), .i_cmd(cmd2),
        .i_deadtime(dt2), .i_trip_n(trip2_n), .i_fault_clear(clr2),
        .o_gate_hi(g2_hi), .o_gate_lo(g2_lo), .o_fault(fault2), .o_active(active2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic [1:0] hi;
        logic [1:0] lo;
        logic       fault;
        logic       active;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expectation for the sample taken after edge k+m, where edge k follows this call.
    task automatic exp_after(input int m, input logic [1:0] hi, input logic [1:0] lo,
                             input logic flt, input logic act, input string name);
        exp_t e;
        e.cyc    = cyc + 1 + m;
        e.hi     = hi;
        e.lo     = lo;
        e.fault  = flt;
        e.active = act;
        e.name   = name;
        sb_q.push_back(e);
    endtask

    task automatic exp_window(input int d, input logic [1:0] hg, input logic [1:0] lg,
                              input logic ag, input logic [1:0] he, input logic [1:0] le,
                              input string name);
        for (int m = 0; m < d; m++) exp_after(m, hg, lg, 1'b0, ag, {name, "_gap"});
        exp_after(d, he, le, 1'b0, 1'b1, {name, "_on"});
    endtask

    // Monitor: compare due expectations, and the shoot-through invariant every cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check(sb_q[i].name, {o_gate_hi, o_gate_lo, o_fault, o_active},
                      {sb_q[i].hi, sb_q[i].lo, sb_q[i].fault, sb_q[i].active});
                sb_q.delete(i);
            end
        end
        check("no_shoot", o_gate_hi & o_gate_lo, 0);
    end

    int gap2 [4] = '{default: 0};
    bit seen2 [4] = '{default: 1'b0};
    int n_gaps = 0;

    always @(negedge clk) begin
        check("no_shoot4", g2_hi & g2_lo, 0);
        for (int j = 0; j < 4; j++) begin
            if (g2_hi[j] | g2_lo[j]) begin
                if (seen2[j] && gap2[j] > 0) begin
                    check("scale_gap", (gap2[j] >= 4095) ? 32'd4095 : gap2[j], 4095);
                    n_gaps <= n_gaps + 1;
                end
                gap2[j]  <= 0;
                seen2[j] <= 1'b1;
            end else if (seen2[j]) begin
                gap2[j] <= gap2[j] + 1;
            end
        end
    end

    task automatic main_seq();
        tick(1);
        exp_after(0, 2'b00, 2'b00, 1'b0, 1'b0, "reset");
        tick(2);
        i_reset = 1'b1;
        tick(2);
        i_enable = 1'b1;
        exp_window(5, 2'b00, 2'b00, 1'b0, 2'b01, 2'b10, "startup");
        tick(8);
        i_cmd = 2'b00;
        exp_window(5, 2'b00, 2'b10, 1'b1, 2'b00, 2'b11, "toggle_d5");
        tick(8);
        i_deadtime = 10'd0;
        i_cmd = 2'b01;
        exp_window(1, 2'b00, 2'b10, 1'b1, 2'b01, 2'b10, "toggle_d0");
        tick(4);
        i_deadtime = 10'd8;
        i_cmd = 2'b00;
        exp_window(8, 2'b00, 2'b10, 1'b1, 2'b01, 2'b10, "reversal");
        tick(1);
        i_cmd = 2'b01;
        i_deadtime = 10'd2;
        tick(12);
        i_deadtime = 10'd5;
        i_cmd = 2'b00;
        exp_after(0, 2'b00, 2'b10, 1'b0, 1'b1, "dead_entry");
        tick(2);
        i_enable = 1'b0;
        exp_after(0, 2'b00, 2'b00, 1'b0, 1'b0, "enable_drop");
        tick(2);
        i_enable = 1'b1;
        exp_window(5, 2'b00, 2'b00, 1'b0, 2'b00, 2'b11, "reenable");
        tick(8);
        i_trip_n = 1'b0;
        exp_after(1, 2'b00, 2'b11, 1'b0, 1'b1, "trip_pre");
        exp_after(2, 2'b00, 2'b00, 1'b1, 1'b0, "trip_off");
        exp_after(3, 2'b00, 2'b00, 1'b1, 1'b0, "trip_hold");
        tick(1);
        i_trip_n = 1'b1;
        tick(3);
        i_fault_clear = 1'b1;
        exp_after(0, 2'b00, 2'b00, 1'b1, 1'b0, "clear_ignored");
        tick(1);
        i_fault_clear = 1'b0;
        tick(1);
        i_enable = 1'b0;
        i_fault_clear = 1'b1;
        exp_after(0, 2'b00, 2'b00, 1'b0, 1'b0, "clear_ok");
        tick(1);
        i_fault_clear = 1'b0;
        tick(2);
        i_fault_clear = 1'b1;
        i_trip_n = 1'b0;
        exp_after(1, 2'b00, 2'b00, 1'b0, 1'b0, "sim_pre");
        exp_after(2, 2'b00, 2'b00, 1'b1, 1'b0, "set_beats_clear");
        exp_after(3, 2'b00, 2'b00, 1'b0, 1'b0, "clear_after");
        tick(1);
        i_trip_n = 1'b1;
        tick(4);
        i_fault_clear = 1'b0;
        tick(1);
        i_enable = 1'b1;
        exp_window(5, 2'b00, 2'b00, 1'b0, 2'b00, 2'b11, "restart");
        tick(8);
        #2 i_reset = 1'b0;
        #1 check("async_reset", {o_gate_hi, o_gate_lo, o_fault, o_active}, 0);
        tick(1);
        i_reset = 1'b1;
        exp_window(5, 2'b00, 2'b00, 1'b0, 2'b00, 2'b11, "post_reset");
        tick(8);
    endtask

    task automatic scale_seq();
        tick(3);
        rst2_n = 1'b1;
        en2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick((i % 2 == 0) ? 4300 : 60);
            cmd2 = cmd2 ^ 4'($urandom_range(1, 15));
        end
        tick(4300);
        check("scale_gaps_seen", (n_gaps >= 4) ? 32'd1 : 32'd0, 1);
    endtask

    initial begin
        fork
            main_seq();
            scale_seq();
        join
        tick(10);
        while (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s never sampled at cyc=%0d", sb_q[0].name, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
